// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter.
// No logic; state encoding and fixed values only.
// Imported by the arbiter top and its round-robin picker.
package flash_arb_pkg;

    localparam int         FLASH_ADDR_W = 24;
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
module rr_priority_picker
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] rot;
    int                   pos;

    // Rotate the doubled request vector so bit k is requester (ptr+k) mod N, then take the lowest set bit.
    always_comb begin
        rot   = {req_i, req_i} >> ptr_i;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                pos   = int'(ptr_i) + k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                idx_o = PTR_W'(pos);
            end
        end
    end

    // Expand the chosen index back into a one-hot grant.
    always_comb begin
        grant_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_o[j] = any_o && (idx_o == PTR_W'(j));
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one byte-wide QSPI flash read port among NUM_REQ requesters, round-robin, with a one-entry last-byte bypass.
// Latency: bypass hit grants in cycle 0 and responds in cycle 1; a miss responds one cycle after flash_ready returns.
// Backpressure: requests hold until granted; no grant while the controller is not ready or a transaction is in flight.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = FLASH_ADDR_W,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [7:0]                resp_data,
    output logic                      busy,
    output logic                      timeout_err,
    input  logic                      flash_ready,
    input  logic                      flash_run,
    input  logic [7:0]                flash_rdata,
    output logic                      flash_read_en,
    output logic [ADDR_W-1:0]         flash_addr
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    cur_q, cur_d;
    logic [ADDR_W-1:0]   flash_addr_q, flash_addr_d;
    logic [7:0]          resp_data_q, resp_data_d;
    logic                last_valid_q, last_valid_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [7:0]          last_data_q, last_data_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [NUM_REQ-1:0]  grant_c;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Mux out the address of the picked requester.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state and datapath updates; grants only leave IDLE while the controller is ready.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_d         = cur_q;
        flash_addr_d  = flash_addr_q;
        resp_data_d   = resp_data_q;
        last_valid_d  = last_valid_q;
        last_addr_d   = last_addr_q;
        last_data_d   = last_data_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        grant_c       = '0;

        case (state_q)
            ST_IDLE: begin
                if (flash_ready && pick_any) begin
                    grant_c  = pick_grant;
                    cur_d    = pick_idx;
                    rr_ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                    if (last_valid_q && (sel_addr == last_addr_q)) begin
                        resp_data_d = last_data_q;
                        state_d     = ST_RESP;
                    end else begin
                        flash_addr_d = sel_addr;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (flash_run) begin
                    wdog_d  = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flash_ready) begin
                    resp_data_d  = flash_rdata;
                    last_addr_d  = flash_addr_q;
                    last_data_d  = flash_rdata;
                    last_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES)) begin
                    // Hung controller: answer with the filler byte and forget the cached byte.
                    resp_data_d   = TIMEOUT_DATA;
                    timeout_err_d = 1'b1;
                    last_valid_d  = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            cur_q         <= '0;
            flash_addr_q  <= '0;
            resp_data_q   <= '0;
            last_valid_q  <= 1'b0;
            last_addr_q   <= '0;
            last_data_q   <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_q         <= cur_d;
            flash_addr_q  <= flash_addr_d;
            resp_data_q   <= resp_data_d;
            last_valid_q  <= last_valid_d;
            last_addr_q   <= last_addr_d;
            last_data_q   <= last_data_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // One-cycle response strobe for the requester being served; grant and strobe are held low in reset.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = !reset && (state_q == ST_RESP) && (cur_q == PTR_W'(i));
        end
        req_grant = reset ? '0 : grant_c;
    end

    assign busy          = (state_q != ST_IDLE);
    assign flash_read_en = (state_q == ST_ISSUE);
    assign flash_addr    = flash_addr_q;
    assign resp_data     = resp_data_q;
    assign timeout_err   = timeout_err_q;

endmodule
